// File: rtl/irq_pkg.sv
// Shared types and constants for the platform interrupt controller.
// Line i maps to mie bit IRQ_MIE_OFFSET+i and mcause code IRQ_CAUSE_BASE+i.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IRQ_SRV,
    EXC_SRV,
    EXC_IN_IRQ
  } irq_state_t;

  localparam int IRQ_CAUSE_BASE = 16;
  localparam int IRQ_MIE_OFFSET = 16;
  localparam int MAX_IRQ        = 16;
  localparam int IDX_W          = $clog2(MAX_IRQ);

  // mcause value for an interrupt on platform line idx (interrupt bit set).
  function automatic logic [31:0] irq_cause(input logic [IDX_W-1:0] idx);
    return {1'b1, 26'b0, 5'(IRQ_CAUSE_BASE + int'(idx))};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder over the eligible interrupt vector.
// The lowest set index wins; valid flags that any bit is set.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 16
) (
  input  logic [NUM_IRQ-1:0] eligible,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // Scanning downwards lets the lowest set index overwrite any higher one.
  always_comb begin
    valid = |eligible;
    idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Platform interrupt controller: latches request edges, raises one trap for the
// highest-priority enabled line, blocks nesting and acknowledges it on mret.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_IRQ-1:0] irq_req_i,
  input  logic [31:0]        mie_i,
  input  logic               exception_i,
  input  logic               mret_i,
  output logic               irq_o,
  output logic [31:0]        irq_cause_o,
  output logic [NUM_IRQ-1:0] irq_ret_o
);

  irq_state_t         state;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] req_prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clear;
  logic [IDX_W-1:0]   active_idx;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;
  logic               take_irq;
  logic               ack;
  logic               unused_mie;

  assign rise       = irq_req_i & ~req_prev;
  assign eligible   = pending & mie_i[IRQ_MIE_OFFSET +: NUM_IRQ];
  assign unused_mie = ^mie_i;

  irq_prio_enc #(
    .NUM_IRQ(NUM_IRQ)
  ) u_prio (
    .eligible(eligible),
    .valid   (win_valid),
    .idx     (win_idx)
  );

  // Exceptions outrank interrupts in IDLE; outputs are held quiet during reset.
  assign take_irq = rst_ni && (state == IDLE) && !exception_i && win_valid;
  assign ack      = rst_ni && (state == IRQ_SRV) && mret_i;

  always_comb begin
    clear = '0;
    if (ack) begin
      clear[active_idx] = 1'b1;
    end
  end

  assign irq_o       = take_irq;
  assign irq_cause_o = take_irq ? irq_cause(win_idx) : '0;
  assign irq_ret_o   = clear;

  // A fresh edge on the line being cleared re-arms it, since rise is ORed in last.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      pending    <= '0;
      req_prev   <= '0;
      active_idx <= '0;
    end else begin
      req_prev <= irq_req_i;
      pending  <= (pending & ~clear) | rise;
      case (state)
        IDLE: begin
          if (exception_i) begin
            state <= EXC_SRV;
          end else if (win_valid) begin
            state      <= IRQ_SRV;
            active_idx <= win_idx;
          end
        end
        IRQ_SRV: begin
          if (mret_i) begin
            state <= IDLE;
          end else if (exception_i) begin
            state <= EXC_IN_IRQ;
          end
        end
        EXC_SRV: begin
          if (mret_i) begin
            state <= IDLE;
          end
        end
        EXC_IN_IRQ: begin
          if (mret_i) begin
            state <= IRQ_SRV;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller that raises the trap request for the core and consumes the `mie` mask and `mret` from the CSR controller.
- Sits between the peripheral interrupt lines and the core's trap logic.
- Edge-detects and latches up to N platform interrupt requests, selects the highest-priority enabled one, and emits `irq_o` together with the matching `mcause` value.
- Blocks nesting until `mret`, then returns a one-hot acknowledge to the serviced peripheral.

Parameters:
- NUM_IRQ, 16, number of platform interrupt lines (1..16); line i maps to `mie` bit 16+i and `mcause` code 16+i.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset; synchronous, active-low.
- irq_req_i  input  NUM_IRQ  peripheral interrupt request lines, level signals sampled on clk_i.
- mie_i  input  32  machine interrupt-enable register from the CSR controller.
- exception_i  input  1  core reports a synchronous exception trap this cycle.
- mret_i  input  1  core executes `mret` this cycle.
- irq_o  output  1  one-cycle interrupt trap request to the core.
- irq_cause_o  output  32  `mcause` value for the interrupt being taken.
- irq_ret_o  output  NUM_IRQ  one-hot, one-cycle acknowledge to the serviced peripheral.

Behaviour:
- Reset (rst_ni=0 at posedge): state=IDLE; pending, req_prev, active_idx, irq_o, irq_cause_o, irq_ret_o all 0.
  - req_prev resets to 0, so a line already high when reset is released is seen as a rising edge on the first clock.
  - Reset asserted mid-service discards all pending and active state; no irq_ret_o is issued.
- Edge detect:
  - req_prev <= irq_req_i every cycle.
  - rise[i] = irq_req_i[i] & ~req_prev[i].
  - pending[i] is set on rise[i] and is independent of the mask.
- Eligible set: eligible[i] = pending[i] & mie_i[16+i].
  - Priority: the lowest index wins.
  - The mask is applied combinationally, so a masked pending bit becomes eligible as soon as the mask bit is set.
- States: IDLE, IRQ_SRV, EXC_SRV, EXC_IN_IRQ.
- IDLE:
  - exception_i -> EXC_SRV; irq_o stays 0 that cycle, because the exception has priority.
  - Otherwise, if |eligible: irq_o=1 for exactly that cycle, irq_cause_o={1'b1, 26'b0, 5'(16+idx)}, active_idx<=idx, -> IRQ_SRV.
  - irq_o and irq_cause_o are combinational from registered state and pending (zero-cycle latency from an eligible pending bit).
  - Pending-to-trap latency after an edge on irq_req_i is therefore 1 cycle.
- IRQ_SRV:
  - irq_o=0 (no nesting).
  - exception_i -> EXC_IN_IRQ.
  - mret_i: irq_ret_o[active_idx]=1 for one cycle, clear pending[active_idx], -> IDLE.
- EXC_SRV:
  - mret_i -> IDLE.
  - exception_i while in this state: stays in EXC_SRV (no nesting counter).
- EXC_IN_IRQ:
  - mret_i -> IRQ_SRV; this returns from the exception only, so no irq_ret_o.
  - exception_i: stays in EXC_IN_IRQ.
- irq_cause_o is 0 whenever irq_o=0.
- Simultaneous events:
  - mret_i and exception_i in the same cycle: exception_i is ignored (illegal per core contract); mret processing wins.
  - rise on active_idx in the same cycle as its clear: set wins, and pending stays 1.
  - A new edge on a line that is already pending is absorbed; edges are not counted.
- mret_i in IDLE is ignored; there is no state change and no ack.
- A mask cleared while a line is in IRQ_SRV does not abort service; the ack is still issued on mret.

Decomposition:
- Shared package irq_pkg holds:
  - irq_state_t enum {IDLE, IRQ_SRV, EXC_SRV, EXC_IN_IRQ};
  - IRQ_CAUSE_BASE = 16;
  - IRQ_MIE_OFFSET = 16;
  - MAX_IRQ = 16.
- Natural sub-module: irq_prio_enc (NUM_IRQ-bit eligible vector -> valid + index, lowest index wins).
- Edge detect, pending register and FSM stay in the top.

Test Plan:
- Single IRQ: mie_i=32'h0001_0000, pulse irq_req_i[0] for 1 cycle -> irq_o=1 for 1 cycle next cycle, irq_cause_o=32'h8000_0010; mret 5 cycles later -> irq_ret_o=16'h0001 for 1 cycle, state IDLE.
- Priority/no nesting: mie_i=32'hFFFF_0000, rise lines 3 and 5 in the same cycle -> cause 32'h8000_0013.
  - After mret: ack 16'h0008, then next cycle irq_o with cause 32'h8000_0015.
  - No irq_o between these two traps.
- Masking: mie_i=0, rise line 2 -> no irq_o for 10 cycles; set mie_i=32'h0004_0000 -> irq_o in the same cycle with cause 32'h8000_0012.
- Exception precedence: line 1 eligible and exception_i=1 in the same IDLE cycle -> irq_o=0.
  - mret -> IDLE, then irq_o with cause 32'h8000_0011.
- Exception inside handler: in IRQ_SRV on line 4, exception_i=1.
  - First mret -> no ack, state IRQ_SRV.
  - Second mret -> irq_ret_o=16'h0010.
- Reset mid-service: in IRQ_SRV, with lines 0 and 7 pending and line 7 held high, drive rst_ni=0 for 1 cycle.
  - Required: all outputs 0 and no ack.
  - After release, line 7 is seen as an edge -> irq_o with cause 32'h8000_0017 (mie set).
